q1_bit_packer: RTL

Downstream consumer of the stage-A registered output Q1, operating in parallel with stage C. It samples Q1 one bit per qualified cycle and packs the bits LSB-first into WIDTH-bit words. Words are buffered in a small FIFO and handed to the next stage over a valid/ready interface. A flush pushes a partial word; overflow is flagged, never stalls the source.

---
 rtl/q1_pack_pkg.sv | 23 ++
 rtl/q1_pack_fifo.sv | 60 ++++++
 rtl/q1_bit_packer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/q1_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : q1_pack_pkg
// Purpose : Shared types and helpers for the Q1 bit packer. This covers the
//           accumulator state encoding and the length-field width helper.
// Revision: 1.0 - initial release
// ============================================================================
package q1_pack_pkg;

  // Accumulator state. EMPTY means no bits are held, and FILLING means a
  // partial word is in progress.
  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } acc_state_t;

  // Number of bits needed to encode a length in the range 0..width.
  function automatic int calc_lw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : q1_pack_pkg
`default_nettype wire

// File: rtl/q1_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module  : q1_pack_fifo
// Purpose : Register-based first-word-fall-through FIFO. The head entry is
//           visible while the FIFO is not empty. The FIFO accepts a push and a
//           pop in the same cycle even when it is full.
// Revision: 1.0 - initial release
// ============================================================================
module q1_pack_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_push_en;
  logic          w_pop_en;

  // The extra pointer MSB tells full apart from empty when the lower bits match.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop on a full FIFO frees a slot, so a push in the same cycle is legal.
  assign w_pop_en  = pop & ~empty;
  assign w_push_en = push & (~full | w_pop_en);

  // The head is forced to zero while the FIFO is empty, so stale storage never
  // reaches the output.
  assign dout = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Pointer registers. Reset discards every queued word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_en) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop_en)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage array. It needs no reset because the empty flag masks its contents.
  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule : q1_pack_fifo
`default_nettype wire

// File: rtl/q1_bit_packer.sv
`default_nettype none
// ============================================================================
// Module  : q1_bit_packer
// Purpose : Samples Q1 one bit per qualified cycle and packs the bits LSB-first
//           into WIDTH-bit words. Words are queued in a FWFT FIFO and handed
//           on over valid/ready. A flush pushes the partial word. A full FIFO
//           drops the word and sets a sticky overflow flag, so the source is
//           never stalled.
// Revision: 1.0 - initial release
// ============================================================================
module q1_bit_packer
  import q1_pack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = calc_lw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    out_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int          DW     = WIDTH + LW;
  localparam logic [LW-1:0] c_last = LW'(WIDTH - 1);

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_acc_bit;
  logic [WIDTH-1:0] w_word;
  logic [LW-1:0]    r_cnt;
  logic [LW-1:0]    w_cnt_nxt;
  logic [LW-1:0]    w_len;
  logic             w_complete;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_push;
  logic             w_full;
  logic             w_empty;
  logic             r_overflow;
  logic [DW-1:0]    w_fifo_din;
  logic [DW-1:0]    w_fifo_dout;

  // Place the incoming bit at the current fill position.
  assign w_acc_bit = {{(WIDTH-1){1'b0}}, bit_in} << r_cnt;

  // Accumulator state register. The count and the shift register are held
  // alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic, and the decision whether a word is pushed this cycle.
  // A word built this cycle includes the same-cycle bit, so a flush that
  // coincides with word completion pushes exactly one full-length word.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_word      = r_acc;
    w_len       = r_cnt;
    w_complete  = 1'b0;
    w_push      = 1'b0;

    if (bit_en) begin
      w_word     = r_acc | w_acc_bit;
      w_len      = r_cnt + LW'(1);
      w_complete = (r_cnt == c_last);
    end

    w_push = w_complete || (flush && (w_len != '0));

    case (r_state)
      EMPTY:   if (bit_en && !w_push) w_state_nxt = FILLING;
      FILLING: if (w_push)            w_state_nxt = EMPTY;
      default:                        w_state_nxt = EMPTY;
    endcase

    if (w_push) begin
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
    end else begin
      w_acc_nxt = w_word;
      w_cnt_nxt = w_len;
    end
  end

  // Pop, and push-with-room decision. A same-cycle pop makes room on a full FIFO.
  assign w_pop       = ~w_empty & out_ready;
  assign w_fifo_push = w_push & (~w_full | w_pop);
  assign w_fifo_din  = {w_len, w_word};

  // Sticky overflow flag. It is set when a word is lost on a full FIFO that
  // is not draining this cycle, and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  q1_pack_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_fifo_push),
    .din   (w_fifo_din),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid = ~w_empty;
  assign out_data  = w_fifo_dout[WIDTH-1:0];
  assign out_len   = w_fifo_dout[DW-1:WIDTH];
  assign overflow  = r_overflow;

endmodule : q1_bit_packer
`default_nettype wire
